// File: rtl/cim_bus_rx.sv
// CiM-side bus receiver: decodes parameter-stream and EEG patch-broadcast instructions
// into single-word local memory writes, with ID filtering and sticky error flags.
module cim_bus_rx #(
  parameter int unsigned ID           = 0,
  parameter int unsigned NUM_CIMS     = 64,
  parameter int unsigned N_STORAGE    = 16,
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned NUM_SAMPLES  = 3840,
  parameter int unsigned EEG_BASE     = 0,
  parameter int unsigned BUS_OP_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [BUS_OP_WIDTH-1:0]      bus_op_read,
  input  logic [3*N_STORAGE-1:0]       bus_data_read,
  input  logic [$clog2(NUM_CIMS)-1:0]  bus_target_or_sender_read,
  output logic                         mem_wr_en,
  output logic [ADDR_W-1:0]            mem_wr_addr,
  output logic [N_STORAGE-1:0]         mem_wr_data,
  output logic                         param_done,
  output logic                         patch_done,
  output logic                         idle,
  output logic                         err_overflow,
  output logic                         err_protocol
);

  localparam int unsigned LaneW = $clog2(NUM_CIMS);
  localparam int unsigned SampW = $clog2(NUM_SAMPLES + 1);

  localparam logic [BUS_OP_WIDTH-1:0] OpParamStart = BUS_OP_WIDTH'(1);
  localparam logic [BUS_OP_WIDTH-1:0] OpParam      = BUS_OP_WIDTH'(2);
  localparam logic [BUS_OP_WIDTH-1:0] OpPatchStart = BUS_OP_WIDTH'(3);
  localparam logic [BUS_OP_WIDTH-1:0] OpPatch      = BUS_OP_WIDTH'(4);

  typedef enum logic [1:0] {StIdle, StParamRx, StPatchRx} state_e;
  state_e state_q, state_d;

  logic [ADDR_W-1:0]              addr_q, addr_d, rem_q, rem_d, slot_q, slot_d;
  logic [2:0][N_STORAGE-1:0]      ser_q, ser_d;
  logic [1:0]                     ser_cnt_q, ser_cnt_d;
  logic [LaneW-1:0]               lane_q, lane_d;
  logic [SampW-1:0]               samp_q, samp_d;
  logic                           wr_en_d, pdone_d, tdone_d, idle_d, err_ovf_d, err_prot_d;
  logic [ADDR_W-1:0]              wr_addr_d;
  logic [N_STORAGE-1:0]           wr_data_d;

  logic              for_me, op_pstart, op_pstream, op_bstart, op_bcast;
  logic [ADDR_W-1:0] start_addr, start_len;
  logic              last_param_wr;

  assign for_me        = bus_target_or_sender_read == LaneW'(ID);
  assign op_pstart     = (bus_op_read == OpParamStart) && for_me;
  assign op_pstream    = (bus_op_read == OpParam) && for_me;
  assign op_bstart     = bus_op_read == OpPatchStart;
  assign op_bcast      = bus_op_read == OpPatch;
  assign start_addr    = bus_data_read[ADDR_W-1:0];
  assign start_len     = bus_data_read[N_STORAGE +: ADDR_W];
  // The pending word being drained this cycle completes the stream.
  assign last_param_wr = (ser_cnt_q != 2'd0) && (rem_q == ADDR_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (op_pstart)      state_d = (start_len == '0) ? StIdle : StParamRx;
        else if (op_bstart) state_d = StPatchRx;
      end
      StParamRx: begin
        if (op_pstart)          state_d = (start_len == '0) ? StIdle : StParamRx;
        else if (last_param_wr) state_d = StIdle;
      end
      StPatchRx: begin
        if (op_bcast && !op_bstart && samp_q == SampW'(NUM_SAMPLES - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    rem_d      = rem_q;
    ser_d      = ser_q;
    ser_cnt_d  = ser_cnt_q;
    lane_d     = lane_q;
    slot_d     = slot_q;
    samp_d     = samp_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = mem_wr_addr;
    wr_data_d  = mem_wr_data;
    pdone_d    = 1'b0;
    tdone_d    = 1'b0;
    err_ovf_d  = err_overflow;
    err_prot_d = err_protocol;
    case (state_q)
      StIdle: begin
        if (op_pstart) begin
          addr_d  = start_addr;
          rem_d   = start_len;
          pdone_d = start_len == '0;
        end else if (op_bstart) begin
          lane_d = '0;
          slot_d = '0;
          samp_d = '0;
        end
      end
      StParamRx: begin
        if (op_pstart) begin
          addr_d    = start_addr;
          rem_d     = start_len;
          ser_cnt_d = 2'd0;
          pdone_d   = start_len == '0;
        end else begin
          if (op_bstart) err_prot_d = 1'b1;
          if (ser_cnt_q != 2'd0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = ser_q[0];
            addr_d    = addr_q + ADDR_W'(1);
            rem_d     = rem_q - ADDR_W'(1);
            ser_d[0]  = ser_q[1];
            ser_d[1]  = ser_q[2];
            ser_cnt_d = ser_cnt_q - 2'd1;
            if (last_param_wr) begin
              pdone_d   = 1'b1;
              ser_cnt_d = 2'd0;
            end
          end
          if (op_pstream) begin
            if (ser_cnt_q >= 2'd2) begin
              err_ovf_d = 1'b1;
            end else if (!last_param_wr) begin
              ser_d     = bus_data_read;
              ser_cnt_d = 2'd3;
            end
          end
        end
      end
      StPatchRx: begin
        if (op_bstart) begin
          err_prot_d = 1'b1;
          lane_d     = '0;
          slot_d     = '0;
          samp_d     = '0;
        end else if (op_bcast) begin
          if (lane_q == LaneW'(ID)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_W'(EEG_BASE) + slot_q;
            wr_data_d = bus_data_read[N_STORAGE-1:0];
          end
          if (lane_q == LaneW'(NUM_CIMS - 1)) begin
            lane_d = '0;
            slot_d = slot_q + ADDR_W'(1);
          end else begin
            lane_d = lane_q + LaneW'(1);
          end
          samp_d  = samp_q + SampW'(1);
          tdone_d = samp_q == SampW'(NUM_SAMPLES - 1);
        end
      end
      default: ;
    endcase
    idle_d = (state_d == StIdle) && (ser_cnt_d == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q       <= '0;
      rem_q        <= '0;
      ser_q        <= '0;
      ser_cnt_q    <= 2'd0;
      lane_q       <= '0;
      slot_q       <= '0;
      samp_q       <= '0;
      mem_wr_en    <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      param_done   <= 1'b0;
      patch_done   <= 1'b0;
      idle         <= 1'b1;
      err_overflow <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      ser_q        <= ser_d;
      ser_cnt_q    <= ser_cnt_d;
      lane_q       <= lane_d;
      slot_q       <= slot_d;
      samp_q       <= samp_d;
      mem_wr_en    <= wr_en_d;
      mem_wr_addr  <= wr_addr_d;
      mem_wr_data  <= wr_data_d;
      param_done   <= pdone_d;
      patch_done   <= tdone_d;
      idle         <= idle_d;
      err_overflow <= err_ovf_d;
      err_protocol <= err_prot_d;
    end
  end

endmodule

// File: tb/tb_cim_bus_rx.sv
// Scoreboard bench for cim_bus_rx: stimulus pushes expected write/done events, per-DUT
// monitors pop and compare whenever a write or done pulse appears.
module tb_cim_bus_rx;

  localparam logic [2:0] NOP = 3'd0, PSTART = 3'd1, PSTREAM = 3'd2, BSTART = 3'd3, BCAST = 3'd4;

  typedef struct packed {
    logic        wr;
    logic [10:0] addr;
    logic [15:0] data;
    logic        pd;
    logic        td;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  op_a = NOP, op_b = NOP;
  logic [47:0] data = '0;
  logic [5:0]  tgt_a = '0;
  logic [1:0]  tgt_b = '0;

  logic        a_wr, a_pd, a_td, a_idle, a_ovf, a_prot;
  logic [10:0] a_addr;
  logic [15:0] a_data;
  logic        b_wr, b_pd, b_td, b_idle, b_ovf, b_prot;
  logic [10:0] b_addr;
  logic [15:0] b_data;

  ev_t qa[$];
  ev_t qb[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  cim_bus_rx #(.ID(5), .NUM_CIMS(64), .NUM_SAMPLES(12), .EEG_BASE(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus_op_read(op_a), .bus_data_read(data),
    .bus_target_or_sender_read(tgt_a), .mem_wr_en(a_wr), .mem_wr_addr(a_addr),
    .mem_wr_data(a_data), .param_done(a_pd), .patch_done(a_td), .idle(a_idle),
    .err_overflow(a_ovf), .err_protocol(a_prot)
  );

  cim_bus_rx #(.ID(2), .NUM_CIMS(4), .NUM_SAMPLES(12), .EEG_BASE(32)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus_op_read(op_b), .bus_data_read(data),
    .bus_target_or_sender_read(tgt_b), .mem_wr_en(b_wr), .mem_wr_addr(b_addr),
    .mem_wr_data(b_data), .param_done(b_pd), .patch_done(b_td), .idle(b_idle),
    .err_overflow(b_ovf), .err_protocol(b_prot)
  );

  always @(negedge clk) begin
    if (rst_n && (a_wr || a_pd || a_td)) begin
      ev_t e;
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_event got wr=%0b addr=%0d data=%0d pd=%0b td=%0b, none expected",
                 a_wr, a_addr, a_data, a_pd, a_td);
      end else begin
        e = qa.pop_front();
        if (a_wr !== e.wr || a_pd !== e.pd || a_td !== e.td ||
            (e.wr && (a_addr !== e.addr || a_data !== e.data))) begin
          errors++;
          $display("FAIL a_event got wr=%0b addr=%0d data=%0d pd=%0b td=%0b exp wr=%0b addr=%0d data=%0d pd=%0b td=%0b",
                   a_wr, a_addr, a_data, a_pd, a_td, e.wr, e.addr, e.data, e.pd, e.td);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (b_wr || b_pd || b_td)) begin
      ev_t e;
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_event got wr=%0b addr=%0d data=%0d pd=%0b td=%0b, none expected",
                 b_wr, b_addr, b_data, b_pd, b_td);
      end else begin
        e = qb.pop_front();
        if (b_wr !== e.wr || b_pd !== e.pd || b_td !== e.td ||
            (e.wr && (b_addr !== e.addr || b_data !== e.data))) begin
          errors++;
          $display("FAIL b_event got wr=%0b addr=%0d data=%0d pd=%0b td=%0b exp wr=%0b addr=%0d data=%0d pd=%0b td=%0b",
                   b_wr, b_addr, b_data, b_pd, b_td, e.wr, e.addr, e.data, e.pd, e.td);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  // Drive one opcode for one sampling edge; sel_b routes it to the patch DUT.
  task automatic drv(input bit sel_b, input logic [2:0] op, input int tgt,
                     input int d0, input int d1, input int d2);
    if (sel_b) op_b = op;
    else       op_a = op;
    tgt_a = 6'(tgt);
    data  = {16'(d2), 16'(d1), 16'(d0)};
    @(posedge clk);
    #1;
    op_a = NOP;
    op_b = NOP;
  endtask

  task automatic nop(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_a(input bit wr, input int addr, input int d, input bit pd);
    qa.push_back('{wr: wr, addr: 11'(addr), data: 16'(d), pd: pd, td: 1'b0});
  endtask

  task automatic exp_b(input bit wr, input int addr, input int d, input bit td);
    qb.push_back('{wr: wr, addr: 11'(addr), data: 16'(d), pd: 1'b0, td: td});
  endtask

  initial begin
    nop(3);
    rst_n = 1'b1;
    nop(1);
    chk("reset_idle_a", {31'd0, a_idle}, 1);
    chk("reset_idle_b", {31'd0, b_idle}, 1);
    chk("reset_errs_a", {30'd0, a_ovf, a_prot}, 0);
    chk("reset_wr_a", {31'd0, a_wr}, 0);

    // Param stream: 7 words from addr 100; words 8 and 9 must be dropped.
    drv(0, PSTART, 5, 100, 7, 0);
    chk("param_rx_not_idle", {31'd0, a_idle}, 0);
    drv(0, PSTREAM, 5, 1, 2, 3);
    exp_a(1, 100, 1, 0); exp_a(1, 101, 2, 0); exp_a(1, 102, 3, 0);
    nop(2);
    drv(0, PSTREAM, 5, 4, 5, 6);
    exp_a(1, 103, 4, 0); exp_a(1, 104, 5, 0); exp_a(1, 105, 6, 0);
    nop(2);
    drv(0, PSTREAM, 5, 7, 8, 9);
    exp_a(1, 106, 7, 1);
    nop(5);
    chk("param_back_idle", {31'd0, a_idle}, 1);
    chk("param_q_drained", qa.size(), 0);

    // Filtering: same sequence to target 4 produces nothing.
    drv(0, PSTART, 4, 100, 7, 0);
    drv(0, PSTREAM, 4, 1, 2, 3);
    chk("filter_idle_1", {31'd0, a_idle}, 1);
    nop(2);
    drv(0, PSTREAM, 4, 4, 5, 6);
    nop(4);
    chk("filter_idle_2", {31'd0, a_idle}, 1);
    drv(0, PSTART, 5, 50, 0, 0);
    exp_a(0, 0, 0, 1);
    nop(3);
    chk("zero_len_idle", {31'd0, a_idle}, 1);

    // Overflow: second stream op one cycle after the first is ignored.
    drv(0, PSTART, 5, 200, 6, 0);
    drv(0, PSTREAM, 5, 11, 12, 13);
    exp_a(1, 200, 11, 0); exp_a(1, 201, 12, 0); exp_a(1, 202, 13, 0);
    drv(0, PSTREAM, 5, 14, 15, 16);
    nop(1);
    chk("overflow_flag", {31'd0, a_ovf}, 1);
    drv(0, PSTREAM, 5, 17, 18, 19);
    exp_a(1, 203, 17, 0); exp_a(1, 204, 18, 0); exp_a(1, 205, 19, 1);
    nop(5);
    chk("overflow_idle", {31'd0, a_idle}, 1);

    // Protocol error: patch start during a parameter stream.
    drv(0, PSTART, 5, 300, 4, 0);
    drv(0, PSTREAM, 5, 21, 22, 23);
    exp_a(1, 300, 21, 0); exp_a(1, 301, 22, 0); exp_a(1, 302, 23, 0);
    drv(0, BSTART, 0, 0, 0, 0);
    nop(1);
    drv(0, PSTREAM, 5, 24, 25, 26);
    exp_a(1, 303, 24, 1);
    nop(5);
    chk("protocol_flag", {31'd0, a_prot}, 1);
    chk("protocol_idle", {31'd0, a_idle}, 1);
    chk("protocol_q_drained", qa.size(), 0);

    // Patch load on DUT B (ID=2 of 4), with a restart midway.
    drv(1, BSTART, 0, 0, 0, 0);
    chk("patch_not_idle", {31'd0, b_idle}, 0);
    for (int i = 0; i < 3; i++) drv(1, BCAST, 0, 10 + i, 0, 0);
    exp_b(1, 32, 12, 0);
    drv(1, BSTART, 0, 0, 0, 0);
    nop(1);
    chk("patch_restart_prot", {31'd0, b_prot}, 1);
    exp_b(1, 32, 42, 0); exp_b(1, 33, 46, 0); exp_b(1, 34, 50, 0); exp_b(0, 0, 0, 1);
    for (int i = 0; i < 12; i++) drv(1, BCAST, 0, 40 + i, 0, 0);
    nop(3);
    chk("patch_idle", {31'd0, b_idle}, 1);
    chk("patch_q_drained", qb.size(), 0);

    // Reset mid-stream: loaded words are discarded, all flags cleared.
    drv(0, PSTART, 5, 400, 5, 0);
    drv(0, PSTREAM, 5, 31, 32, 33);
    rst_n = 1'b0;
    nop(2);
    rst_n = 1'b1;
    nop(5);
    chk("rst_idle", {31'd0, a_idle}, 1);
    chk("rst_ovf", {31'd0, a_ovf}, 0);
    chk("rst_prot", {31'd0, a_prot}, 0);
    chk("rst_addr", {21'd0, a_addr}, 0);
    chk("rst_data", {16'd0, a_data}, 0);
    chk("rst_prot_b", {31'd0, b_prot}, 0);

    nop(10);
    chk("final_qa_empty", qa.size(), 0);
    chk("final_qb_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
